bus_master_if: RTL

Master-side bus interface between a CPU pipeline stage and the shared SoC bus. It does four things: accepts one word access from the pipeline, requests and waits for arbiter grant, and drives the address strobe. It then consumes the slave mux's multiplexed `rd_data`/`rdy_` pair and stalls the pipeline until the slave responds. It sits directly downstream of the slave read-data mux and upstream of the pipeline register that takes the read word.

---
 rtl/bus_master_if_pkg.sv | 30 +++
 rtl/bus_timeout_ctr.sv | 31 +++
 rtl/bus_master_if.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/bus_master_if_pkg.sv
// Shared types and constants for the bus master interface.
// Holds the FSM encoding, bus polarity constants and timeout counter sizing.
package bus_master_if_pkg;

   typedef enum logic [1:0] {
      BUS_IF_STATE_IDLE   = 2'd0,
      BUS_IF_STATE_REQ    = 2'd1,
      BUS_IF_STATE_ACCESS = 2'd2,
      BUS_IF_STATE_STALL  = 2'd3
   } BusIfStateBus;

   localparam logic READ     = 1'b1;
   localparam logic WRITE    = 1'b0;
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   localparam int WORD_ADDR_W = 30;
   localparam int WORD_DATA_W = 32;

   typedef logic [WORD_ADDR_W-1:0] WordAddrBus;
   typedef logic [WORD_DATA_W-1:0] WordDataBus;

   // The timeout counter is never narrower than 8 bits.
   function automatic int ctrWidth(input int limit);
      int w;
      w = $clog2(limit + 1);
      return (w < 8) ? 8 : w;
   endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Counts ACCESS cycles and flags the cycle in which the limit is reached.
// Cleared on entry to ACCESS so the first ACCESS cycle counts as cycle 1.
module bus_timeout_ctr
   import bus_master_if_pkg::*;
#(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic reset_,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CTR_W = ctrWidth(LIMIT);

   logic [CTR_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!reset_) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (enable) begin
         r_count <= r_count + CTR_W'(1);
      end
   end

   assign expired = enable && (r_count == CTR_W'(LIMIT - 1));

endmodule

// File: rtl/bus_master_if.sv
// Master-side bus interface: one pipeline word access, arbitration, strobe and ready wait.
// Optional ACCESS timeout abort is enabled by defining BUS_MASTER_IF_TIMEOUT_EN.
module bus_master_if
   import bus_master_if_pkg::*;
#(
   parameter int ADDR_W      = 30,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic              req_,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              stall,
   input  logic              flush,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              err,
   output logic              bus_req_,
   input  logic              bus_grnt_,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_as_,
   output logic              bus_rw,
   output logic [DATA_W-1:0] bus_wr_data,
   input  logic [DATA_W-1:0] bus_rd_data,
   input  logic              bus_rdy_
);

   BusIfStateBus      r_state;
   logic              r_busReq_;
   logic              r_busAs_;
   logic              r_busRw;
   logic [ADDR_W-1:0] r_busAddr;
   logic [DATA_W-1:0] r_busWrData;
   logic [DATA_W-1:0] r_rdData;
   logic              r_err;

   BusIfStateBus      w_nextState;
   logic              w_busReq_;
   logic              w_busAs_;
   logic              w_busRw;
   logic [ADDR_W-1:0] w_busAddr;
   logic [DATA_W-1:0] w_busWrData;
   logic [DATA_W-1:0] w_rdData;
   logic              w_err;
   logic              w_expired;

`ifdef BUS_MASTER_IF_TIMEOUT_EN
   logic w_ctrClear;
   logic w_ctrEnable;

   assign w_ctrClear  = (r_state == BUS_IF_STATE_REQ) && !flush && (bus_grnt_ == ENABLE_);
   assign w_ctrEnable = (r_state == BUS_IF_STATE_ACCESS);

   bus_timeout_ctr #(
      .LIMIT (TIMEOUT_CYC)
   ) u_timeoutCtr (
      .clk     (clk),
      .reset_  (reset_),
      .clear   (w_ctrClear),
      .enable  (w_ctrEnable),
      .expired (w_expired)
   );
`else
   assign w_expired = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_) begin
         r_state     <= BUS_IF_STATE_IDLE;
         r_busReq_   <= DISABLE_;
         r_busAs_    <= DISABLE_;
         r_busRw     <= READ;
         r_busAddr   <= '0;
         r_busWrData <= '0;
         r_rdData    <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_busReq_   <= w_busReq_;
         r_busAs_    <= w_busAs_;
         r_busRw     <= w_busRw;
         r_busAddr   <= w_busAddr;
         r_busWrData <= w_busWrData;
         r_rdData    <= w_rdData;
         r_err       <= w_err;
      end
   end

   // Ready completion takes priority over the timeout in the same cycle.
   always_comb begin
      w_nextState = r_state;
      w_busReq_   = r_busReq_;
      w_busAs_    = r_busAs_;
      w_busRw     = r_busRw;
      w_busAddr   = r_busAddr;
      w_busWrData = r_busWrData;
      w_rdData    = r_rdData;
      w_err       = 1'b0;

      case (r_state)
         BUS_IF_STATE_IDLE: begin
            if (!req_ && !flush) begin
               w_busReq_   = ENABLE_;
               w_busAddr   = addr;
               w_busRw     = rw;
               w_busWrData = wr_data;
               w_nextState = BUS_IF_STATE_REQ;
            end
         end
         BUS_IF_STATE_REQ: begin
            if (flush) begin
               w_busReq_   = DISABLE_;
               w_busAddr   = '0;
               w_busRw     = READ;
               w_busWrData = '0;
               w_nextState = BUS_IF_STATE_IDLE;
            end else if (bus_grnt_ == ENABLE_) begin
               w_busAs_    = ENABLE_;
               w_nextState = BUS_IF_STATE_ACCESS;
            end
         end
         BUS_IF_STATE_ACCESS: begin
            w_busAs_ = DISABLE_;
            if (bus_rdy_ == ENABLE_) begin
               w_busReq_   = DISABLE_;
               w_busAddr   = '0;
               w_busRw     = READ;
               w_busWrData = '0;
               if (r_busRw == READ) begin
                  w_rdData = bus_rd_data;
               end
               w_nextState = BUS_IF_STATE_STALL;
            end else if (w_expired) begin
               w_busReq_   = DISABLE_;
               w_busAddr   = '0;
               w_busRw     = READ;
               w_busWrData = '0;
               w_rdData    = '0;
               w_err       = 1'b1;
               w_nextState = BUS_IF_STATE_STALL;
            end
         end
         BUS_IF_STATE_STALL: begin
            if (!stall) begin
               w_nextState = BUS_IF_STATE_IDLE;
            end
         end
         default: begin
            w_nextState = BUS_IF_STATE_IDLE;
         end
      endcase
   end

   assign busy = ((r_state == BUS_IF_STATE_IDLE) && !req_ && !flush) ||
                 ((r_state == BUS_IF_STATE_REQ) && !flush) ||
                 (r_state == BUS_IF_STATE_ACCESS);

   assign rd_data     = r_rdData;
   assign err         = r_err;
   assign bus_req_    = r_busReq_;
   assign bus_as_     = r_busAs_;
   assign bus_rw      = r_busRw;
   assign bus_addr    = r_busAddr;
   assign bus_wr_data = r_busWrData;

endmodule
